// File: rtl/calc_unit.sv
// Accumulator calculator: 32-bit ALU folds the switches into a 16-bit accumulator shown on the LEDs.
// Optional CALC_BTND_EDGE_EN: synchronize btnd and commit once per press instead of every cycle.
module calc_unit (
    input  logic        clk,
    input  logic        btnu,
    input  logic        btnd,
    input  logic        btnl,
    input  logic        btnc,
    input  logic        btnr,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    op_e                op;
    logic signed [31:0] opa;
    logic signed [31:0] opb;
    logic        [4:0]  shamt;
    logic        [15:0] alu_lo;
    logic        [15:0] acc_d;
    logic        [15:0] acc_q;
    logic               commit;

    assign op    = op_e'({btnl, btnc, btnr});
    assign opa   = {{16{acc_q[15]}}, acc_q};
    assign opb   = {{16{sw[15]}}, sw};
    assign shamt = sw[4:0];
    assign led   = acc_q;

    // Each result is formed at full 32-bit width and only its low half is kept.
    always_comb begin
        alu_lo = 16'h0000;
        case (op)
            OP_ADD: alu_lo = 16'(opa + opb);
            OP_SUB: alu_lo = 16'(opa - opb);
            OP_AND: alu_lo = 16'(opa & opb);
            OP_OR:  alu_lo = 16'(opa | opb);
            OP_XOR: alu_lo = 16'(opa ^ opb);
            OP_SLT: alu_lo = {15'h0000, (opa < opb)};
            OP_SLL: alu_lo = 16'(opa << shamt);
            OP_SRA: alu_lo = 16'(opa >>> shamt);
            default: alu_lo = 16'h0000;
        endcase
    end

`ifdef CALC_BTND_EDGE_EN
    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;
    logic prev_d;
    logic prev_q;

    always_comb begin
        sync1_d = btnd;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        commit  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end
`else
    always_comb begin
        commit = btnd;
    end
`endif

    always_comb begin
        acc_d = commit ? alu_lo : acc_q;
    end

    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) begin
            acc_q <= 16'h0000;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_calc_unit.sv
// Scoreboard bench for calc_unit: stimulus queues expected LED values tagged with the cycle
// they should appear; a negedge monitor pops and compares them.
module tb_calc_unit;

    logic        clk = 1'b0;
    logic        btnu;
    logic        btnd;
    logic        btnl;
    logic        btnc;
    logic        btnr;
    logic [15:0] sw;
    logic [15:0] led;

    calc_unit dut (
        .clk (clk),
        .btnu(btnu),
        .btnd(btnd),
        .btnl(btnl),
        .btnc(btnc),
        .btnr(btnr),
        .sw  (sw),
        .led (led)
    );

    always #5 clk = ~clk;

`ifdef CALC_BTND_EDGE_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef struct {
        int unsigned cyc;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: led=0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic expect_at(input int unsigned c, input logic [15:0] e, input string n);
        exp_t item;
        item.cyc  = c;
        item.exp  = e;
        item.name = n;
        sb.push_back(item);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: check missed at cycle %0d, expected 0x%04h", e.name, cyc, e.exp);
            end else begin
                check_output(e.name, led, e.exp);
            end
        end
    end

    // One commit pulse; operands stay stable until the commit has been taken.
    task automatic apply_stimulus(input logic [2:0] op, input logic [15:0] swv,
                                  input logic [15:0] exp, input string name);
        @(negedge clk);
        {btnl, btnc, btnr} = op;
        sw   = swv;
        btnd = 1'b1;
        expect_at(cyc + LAT, exp, name);
        @(negedge clk);
        btnd = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        btnu = 1'b1;
        btnd = 1'b0;
        {btnl, btnc, btnr} = OP_ADD;
        sw = 16'h0000;
        #2 btnu = 1'b0;
        #1 check_output("reset_state", led, 16'h0000);
        repeat (2) @(negedge clk);
        btnu = 1'b1;

        apply_stimulus(OP_ADD, 16'h1234, 16'h1234, "chain_add");
        apply_stimulus(OP_AND, 16'h0FF0, 16'h0230, "chain_and");
        apply_stimulus(OP_OR,  16'h324F, 16'h327F, "chain_or");
        apply_stimulus(OP_SUB, 16'h2D31, 16'h054E, "chain_sub");
        apply_stimulus(OP_XOR, 16'hFFFF, 16'hFAB1, "chain_xor");
        apply_stimulus(OP_XOR, 16'hFFFF, 16'h054E, "xor_back");
        apply_stimulus(OP_SLL, 16'h0004, 16'h54E0, "sll_4");

        apply_stimulus(OP_AND, 16'h0000, 16'h0000, "clear");
        apply_stimulus(OP_ADD, 16'h8000, 16'h8000, "load_8000");
        apply_stimulus(OP_SRA, 16'h0004, 16'hF800, "sra_4");
        apply_stimulus(OP_AND, 16'h0000, 16'h0000, "clear");
        apply_stimulus(OP_ADD, 16'h8000, 16'h8000, "load_8000");
        apply_stimulus(OP_SRA, 16'h0024, 16'hF800, "sra_masked_4");
        apply_stimulus(OP_AND, 16'h0000, 16'h0000, "clear");
        apply_stimulus(OP_ADD, 16'h8000, 16'h8000, "load_8000");
        apply_stimulus(OP_SRA, 16'h0014, 16'hFFFF, "sra_20_signfill");
        apply_stimulus(OP_AND, 16'h0000, 16'h0000, "clear");
        apply_stimulus(OP_ADD, 16'h8000, 16'h8000, "load_8000");
        apply_stimulus(OP_SLL, 16'h0010, 16'h0000, "sll_16_zero");

        apply_stimulus(OP_ADD, 16'hFFFF, 16'hFFFF, "load_ffff");
        apply_stimulus(OP_SLT, 16'h0001, 16'h0001, "slt_neg_lt_pos");
        apply_stimulus(OP_SLT, 16'hFFFF, 16'h0000, "slt_pos_lt_neg");

        apply_stimulus(OP_ADD, 16'h7FFF, 16'h7FFF, "load_7fff");
        apply_stimulus(OP_ADD, 16'h0001, 16'h8000, "add_wrap");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            {btnl, btnc, btnr} = 3'(i);
            sw = 16'h1111 * 16'(i + 1);
            expect_at(cyc + 1, 16'h8000, "hold");
        end

        apply_stimulus(OP_ADD, 16'h9111, 16'h1111, "add_9111");
        @(negedge clk);
        {btnl, btnc, btnr} = OP_ADD;
        sw   = 16'h1111;
        btnd = 1'b1;
        #2 btnu = 1'b0;
        #1 check_output("reset_async", led, 16'h0000);
        expect_at(cyc + 1, 16'h0000, "reset_held_1");
        expect_at(cyc + 2, 16'h0000, "reset_held_2");
        expect_at(cyc + 3, 16'h0000, "reset_released");
        repeat (2) @(negedge clk);
        btnd = 1'b0;
        btnu = 1'b1;
        repeat (2) @(negedge clk);

`ifdef CALC_BTND_EDGE_EN
        {btnl, btnc, btnr} = OP_ADD;
        sw   = 16'h0001;
        btnd = 1'b1;
        expect_at(cyc + 2, 16'h0000, "edge_wait");
        for (int k = 3; k <= 7; k++) begin
            expect_at(cyc + k, 16'h0001, "edge_once");
        end
        repeat (5) @(negedge clk);
        btnd = 1'b0;
`else
        {btnl, btnc, btnr} = OP_ADD;
        sw   = 16'h0001;
        btnd = 1'b1;
        expect_at(cyc + 1, 16'h0001, "b2b_1");
        expect_at(cyc + 2, 16'h0002, "b2b_2");
        expect_at(cyc + 3, 16'h0003, "b2b_3");
        repeat (3) @(negedge clk);
        btnd = 1'b0;
`endif

        repeat (8) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_unit.md
# calc_unit

16-bit accumulator calculator for the board-level demo: a 32-bit ALU combines the current accumulator with the 16-bit switch value and writes the result back. The operation is chosen by three push-buttons and committed by a fourth. The module (`calc_unit`) sits directly between board I/O (buttons, switches) and the LED bank; the accumulator drives the LEDs at all times.

## Interface
Parameters: none.

- clk: input, 1 bit. System clock; all state updates on the rising edge.
- btnu: input, 1 bit. Reset; asynchronous, active-low. Clears the accumulator.
- btnd: input, 1 bit. Commit/enable. While active, the ALU result is written to the accumulator.
- btnl: input, 1 bit. Op-select bit 2 (MSB).
- btnc: input, 1 bit. Op-select bit 1.
- btnr: input, 1 bit. Op-select bit 0 (LSB).
- sw: input, 16 bits. Operand B, treated as signed two's complement.
- led: output, 16 bits. Current accumulator value.

## Operation
- State: one 16-bit accumulator register `acc`; `led = acc` (pure wire, no extra logic).
- Operand A = `acc` sign-extended to 32 bits; operand B = `sw` sign-extended to 32 bits.
- Op select `{btnl,btnc,btnr}`:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 SLT: 1 if A<B signed, else 0.
  - 110 SLL: A << B[4:0].
  - 111 SRA: A >>> B[4:0], arithmetic.
- The ALU is purely combinational and computed at 32 bits. The low 16 bits are written to `acc`; the upper bits are discarded. Overflow wraps silently; there are no flags.
- Shift amount uses only `sw[4:0]`; amounts ≥16 yield 0 (SLL) or sign fill (SRA) in the stored 16 bits.
- When btnd is inactive, `acc` holds its value regardless of sw or op-select changes.

## Timing
- Reset: when btnu=0, `acc` and `led` go to 0x0000 immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- Reset has priority over btnd on every edge, including an edge where both are active.
- Latency: the result appears on `led` one clk edge after the commit is sampled.
- Operands and op-select are sampled at the same edge as btnd. Changing sw or op-select in the same cycle as btnd uses the values present at that edge.
- Back-to-back commits chain: each edge uses the `acc` value produced by the previous edge.
- No handshake. Inputs are assumed synchronous unless the macro below is enabled.

## Configuration
- `CALC_BTND_EDGE_EN`
  - Defined: btnd passes through a 2-flop synchronizer plus a rising-edge detector. `acc` updates exactly once per press, on the clk edge after the synchronized 0→1 transition, adding 2 cycles of commit latency. Synchronizer flops reset to 0.
  - Undefined: btnd is a level enable. `acc` updates on every rising clk edge while btnd=1.

## Test plan
- Reset: btnu=0 mid-operation with btnd=1 -> `led`=0x0000 immediately and stays 0 until btnu=1.
- Chain: from 0, apply one commit per step with the macro undefined -> `led` must match after each step:
  - ADD 0x1234 -> 0x1234.
  - AND 0x0FF0 -> 0x0230.
  - OR 0x324F -> 0x327F.
  - SUB 0x2D31 -> 0x054E.
  - XOR 0xFFFF -> 0xFAB1.
- Shifts:
  - acc=0x054E, SLL sw=0x0004 -> 0x54E0.
  - acc=0x8000, SRA sw=0x0004 -> 0xF800.
  - acc=0x8000, SRA sw=0x0024 (amount 4) -> 0xF800.
- SLT signed:
  - acc=0xFFFF, sw=0x0001 -> 0x0001.
  - acc=0x0001, sw=0xFFFF -> 0x0000.
- Wrap and hold:
  - acc=0x7FFF, ADD 0x0001 -> 0x8000.
  - btnd=0 while sw and op-select toggle for 10 cycles -> `led` unchanged.
- Edge mode (macro defined): hold btnd=1 for 5 cycles with ADD 0x0001 from 0 -> `led`=0x0001 exactly, 3 edges after the press.
